// File: rtl/ysyx_25040111_axi_mem_slave.sv
// AXI4 memory responder used in non-SoC simulation.
// Serves independent read and write channels, one outstanding transaction
// each, from a word-addressed 32-bit array. Supports FIXED/INCR bursts,
// byte strobes, programmable response latency and SLVERR on illegal beats.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   aw* / awready                    write address channel
//   w*  / wready                     write data channel
//   bvalid, bready, bresp, bid       write response channel
//   ar* / arready                    read address channel
//   rvalid, rready, rdata, rresp,
//   rlast, rid                       read data channel
module ysyx_25040111_axi_mem_slave #(
    parameter logic [31:0] BASE   = 32'h8000_0000,
    parameter int          DEPTH  = 4096,
    parameter int          RD_LAT = 2,
    parameter int          WR_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awid,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    output logic [3:0]  bid,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic [3:0]  rid
);

    localparam int          IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LIMIT       = {1'b0, BASE} + 33'(DEPTH) * 33'd4;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  BURST_INCR  = 2'b01;
    localparam logic [15:0] RD_LAST_CNT = 16'((RD_LAT > 0) ? (RD_LAT - 1) : 0);
    localparam logic [15:0] WR_LAST_CNT = 16'((WR_LAT > 0) ? (WR_LAT - 1) : 0);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_WAIT = 2'd2, W_RESP = 2'd3} w_state_t;

    logic [31:0] mem [DEPTH];

    function automatic logic in_range(input logic [31:0] addr);
        return ({1'b0, addr} >= {1'b0, BASE}) && ({1'b0, addr} < LIMIT);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        return IDX_W'(addr[31:2] - BASE[31:2]);
    endfunction

    // WRAP, reserved burst and sizes wider than the bus poison every beat
    function automatic logic bad_ctrl(input logic [2:0] size, input logic [1:0] burst);
        return (size > 3'd2) || burst[1];
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst);
        return (burst == BURST_INCR) ? (addr + (32'd1 << size)) : addr;
    endfunction

    // ---------------- read channel ----------------
    r_state_t    r_state_r, r_state_nx_s;
    logic [31:0] r_addr_r;
    logic [7:0]  r_len_r, r_beat_r;
    logic [2:0]  r_size_r;
    logic [1:0]  r_burst_r;
    logic        r_perr_r;
    logic [15:0] r_cnt_r;
    logic        arready_r, rvalid_r, rlast_r;
    logic [31:0] rdata_r;
    logic [1:0]  rresp_r;
    logic [3:0]  rid_r;
    logic        ar_hs_s, r_hs_s, r_load_s, r_ld_perr_s, r_ld_err_s;
    logic [31:0] r_ld_addr_s, r_ld_data_s;
    logic [7:0]  r_ld_beat_s, r_ld_len_s;

    assign ar_hs_s = arvalid && arready_r;
    assign r_hs_s  = rvalid_r && rready;

    // Read next-state and selection of the beat to present next
    always_comb begin
        r_state_nx_s = r_state_r;
        r_load_s     = 1'b0;
        r_ld_addr_s  = r_addr_r;
        r_ld_beat_s  = r_beat_r;
        r_ld_len_s   = r_len_r;
        r_ld_perr_s  = r_perr_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    if (RD_LAT > 0) begin
                        r_state_nx_s = R_WAIT;
                    end else begin
                        // zero latency: first beat comes straight from the AR inputs
                        r_state_nx_s = R_DATA;
                        r_load_s     = 1'b1;
                        r_ld_addr_s  = araddr;
                        r_ld_beat_s  = 8'd0;
                        r_ld_len_s   = arlen;
                        r_ld_perr_s  = bad_ctrl(arsize, arburst);
                    end
                end else begin
                    r_state_nx_s = R_IDLE;
                end
            end
            R_WAIT: begin
                if (r_cnt_r == RD_LAST_CNT) begin
                    r_state_nx_s = R_DATA;
                    r_load_s     = 1'b1;
                end else begin
                    r_state_nx_s = R_WAIT;
                end
            end
            R_DATA: begin
                if (r_hs_s) begin
                    if (rlast_r) begin
                        r_state_nx_s = R_IDLE;
                    end else begin
                        r_load_s    = 1'b1;
                        r_ld_addr_s = next_addr(r_addr_r, r_size_r, r_burst_r);
                        r_ld_beat_s = r_beat_r + 8'd1;
                    end
                end else begin
                    r_state_nx_s = R_DATA;
                end
            end
            default: r_state_nx_s = R_IDLE;
        endcase
        r_ld_err_s  = r_ld_perr_s || !in_range(r_ld_addr_s);
        r_ld_data_s = r_ld_err_s ? 32'd0 : mem[word_idx(r_ld_addr_s)];
    end

    // Read state, burst context and registered R outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_r <= R_IDLE;
            r_addr_r  <= 32'd0;
            r_len_r   <= 8'd0;
            r_beat_r  <= 8'd0;
            r_size_r  <= 3'd0;
            r_burst_r <= 2'd0;
            r_perr_r  <= 1'b0;
            r_cnt_r   <= 16'd0;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rdata_r   <= 32'd0;
            rresp_r   <= 2'd0;
            rid_r     <= 4'd0;
        end else begin
            r_state_r <= r_state_nx_s;
            arready_r <= (r_state_nx_s == R_IDLE);
            rvalid_r  <= (r_state_nx_s == R_DATA);
            if (ar_hs_s) begin
                r_addr_r  <= araddr;
                r_len_r   <= arlen;
                r_size_r  <= arsize;
                r_burst_r <= arburst;
                r_perr_r  <= bad_ctrl(arsize, arburst);
                r_beat_r  <= 8'd0;
                r_cnt_r   <= 16'd0;
                rid_r     <= arid;
            end else if (r_state_r == R_WAIT) begin
                r_cnt_r <= r_cnt_r + 16'd1;
            end else if (r_hs_s && !rlast_r) begin
                r_addr_r <= r_ld_addr_s;
                r_beat_r <= r_ld_beat_s;
            end
            if (r_load_s) begin
                rdata_r <= r_ld_data_s;
                rresp_r <= r_ld_err_s ? RESP_SLVERR : RESP_OKAY;
                rlast_r <= (r_ld_beat_s == r_ld_len_s);
            end else if (r_hs_s) begin
                rlast_r <= 1'b0;
            end
        end
    end

    // ---------------- write channel ----------------
    w_state_t    w_state_r, w_state_nx_s;
    logic [31:0] w_addr_r;
    logic [7:0]  w_len_r, w_beat_r;
    logic [2:0]  w_size_r;
    logic [1:0]  w_burst_r;
    logic        w_perr_r, w_err_r;
    logic [15:0] w_cnt_r;
    logic        awready_r, wready_r, bvalid_r;
    logic [1:0]  bresp_r;
    logic [3:0]  bid_r;
    logic        aw_hs_s, w_hs_s, w_last_beat_s, w_beat_err_s, mem_we_s;

    assign aw_hs_s       = awvalid && awready_r;
    assign w_hs_s        = wvalid && wready_r;
    assign w_last_beat_s = (w_beat_r == w_len_r);
    // the beat counter, not wlast, decides where the burst ends
    assign w_beat_err_s  = w_perr_r || !in_range(w_addr_r) || (wlast != w_last_beat_s);
    assign mem_we_s      = rst_n && w_hs_s && !w_beat_err_s;

    // Write next-state logic
    always_comb begin
        w_state_nx_s = w_state_r;
        case (w_state_r)
            W_IDLE: begin
                if (aw_hs_s) w_state_nx_s = W_DATA;
                else         w_state_nx_s = W_IDLE;
            end
            W_DATA: begin
                if (w_hs_s && w_last_beat_s) w_state_nx_s = (WR_LAT > 0) ? W_WAIT : W_RESP;
                else                         w_state_nx_s = W_DATA;
            end
            W_WAIT: begin
                if (w_cnt_r == WR_LAST_CNT) w_state_nx_s = W_RESP;
                else                        w_state_nx_s = W_WAIT;
            end
            W_RESP: begin
                if (bvalid_r && bready) w_state_nx_s = W_IDLE;
                else                    w_state_nx_s = W_RESP;
            end
            default: w_state_nx_s = W_IDLE;
        endcase
    end

    // Write state, burst context, sticky error and registered B outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_r <= W_IDLE;
            w_addr_r  <= 32'd0;
            w_len_r   <= 8'd0;
            w_beat_r  <= 8'd0;
            w_size_r  <= 3'd0;
            w_burst_r <= 2'd0;
            w_perr_r  <= 1'b0;
            w_err_r   <= 1'b0;
            w_cnt_r   <= 16'd0;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'd0;
            bid_r     <= 4'd0;
        end else begin
            w_state_r <= w_state_nx_s;
            awready_r <= (w_state_nx_s == W_IDLE);
            wready_r  <= (w_state_nx_s == W_DATA);
            bvalid_r  <= (w_state_nx_s == W_RESP);
            if (aw_hs_s) begin
                w_addr_r  <= awaddr;
                w_len_r   <= awlen;
                w_size_r  <= awsize;
                w_burst_r <= awburst;
                w_perr_r  <= bad_ctrl(awsize, awburst);
                w_beat_r  <= 8'd0;
                w_err_r   <= 1'b0;
                bid_r     <= awid;
            end else if (w_hs_s) begin
                w_err_r <= w_err_r || w_beat_err_s;
                if (w_last_beat_s) begin
                    bresp_r <= (w_err_r || w_beat_err_s) ? RESP_SLVERR : RESP_OKAY;
                    w_cnt_r <= 16'd0;
                end else begin
                    w_addr_r <= next_addr(w_addr_r, w_size_r, w_burst_r);
                    w_beat_r <= w_beat_r + 8'd1;
                end
            end else if (w_state_r == W_WAIT) begin
                w_cnt_r <= w_cnt_r + 16'd1;
            end
        end
    end

    // Byte-lane memory update; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[word_idx(w_addr_r)][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign arready = arready_r;
    assign rvalid  = rvalid_r;
    assign rdata   = rdata_r;
    assign rresp   = rresp_r;
    assign rlast   = rlast_r;
    assign rid     = rid_r;
    assign awready = awready_r;
    assign wready  = wready_r;
    assign bvalid  = bvalid_r;
    assign bresp   = bresp_r;
    assign bid     = bid_r;

endmodule
